// File: rtl/psubsb_pkg.sv
// ============================================================================
// Module   : psubsb_pkg
// Purpose  : Shared lane geometry, saturation values and FSM states for the
//            nibble-serial packed saturating subtractor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package psubsb_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int DATA_W = LANES * LANE_W;
  localparam int CNT_W  = $clog2(LANES);

  localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/psubsb_seq_sat_sub_4bit.sv
// ============================================================================
// Module   : sat_sub_4bit
// Purpose  : Combinational single-lane signed 4-bit subtract with saturation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_sub_4bit
  import psubsb_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] d,
  output logic              ovfl
);

  logic [LANE_W-1:0] w_raw;

  // Two's-complement subtract; the carry out is discarded so nothing leaks to a neighbour lane.
  assign w_raw = a + ~b + 4'd1;
  assign ovfl  = (a[LANE_W-1] != b[LANE_W-1]) && (w_raw[LANE_W-1] != a[LANE_W-1]);
  assign d     = ovfl ? (a[LANE_W-1] ? SAT_NEG : SAT_POS) : w_raw;

endmodule

`default_nettype wire

// File: rtl/psubsb_seq.sv
// ============================================================================
// Module   : psubsb_seq
// Purpose  : Nibble-serial packed saturating subtractor, one lane per clock,
//            start/busy/done handshake. Define PSUBSB_FLAGS_EN for the sat port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module psubsb_seq
  import psubsb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Diff
`ifdef PSUBSB_FLAGS_EN
  ,
  output logic [LANES-1:0]  sat
`endif
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  diff_q, diff_d;
  logic [LANE_W-1:0]  lane_a, lane_b, lane_d;
  logic               lane_ovfl;
  logic               accept;

  assign lane_a = a_q[{cnt_q, 2'b00} +: LANE_W];
  assign lane_b = b_q[{cnt_q, 2'b00} +: LANE_W];

  sat_sub_4bit u_lane (
    .a    (lane_a),
    .b    (lane_b),
    .d    (lane_d),
    .ovfl (lane_ovfl)
  );

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    if (accept) begin
      a_d     = A;
      b_d     = B;
      diff_d  = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          diff_d[{cnt_q, 2'b00} +: LANE_W] = lane_d;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(LANES - 1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Diff = diff_q;

`ifdef PSUBSB_FLAGS_EN
  logic [LANES-1:0] sat_q, sat_d;

  // Flags follow exactly the same clear/write schedule as the Diff nibbles.
  always_comb begin
    sat_d = sat_q;
    if (accept)                sat_d = '0;
    else if (state_q == RUN)   sat_d[cnt_q] = lane_ovfl;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_q <= '0;
    else     sat_q <= sat_d;
  end

  assign sat = sat_q;
`else
  logic unused_ovfl;
  assign unused_ovfl = lane_ovfl;
`endif

endmodule

`default_nettype wire

// File: tb/tb_psubsb_seq.sv
// ============================================================================
// Module   : tb_psubsb_seq
// Purpose  : Self-checking bench for psubsb_seq with a lane-arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_psubsb_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, done;
  logic [15:0] Diff;
`ifdef PSUBSB_FLAGS_EN
  logic [3:0]  sat;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  psubsb_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff)
`ifdef PSUBSB_FLAGS_EN
    ,
    .sat   (sat)
`endif
  );

  // Signed lane difference clamped to [-8,7]; sat bit set whenever clamping occurred.
  function automatic logic [15:0] ref_diff(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    int d;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      d = int'($signed(a[i*4 +: 4])) - int'($signed(b[i*4 +: 4]));
      if (d > 7)  d = 7;
      if (d < -8) d = -8;
      r[i*4 +: 4] = d[3:0];
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_sat(input logic [15:0] a, input logic [15:0] b);
    logic [3:0] s;
    int d;
    for (int i = 0; i < 4; i++) begin
      d = int'($signed(a[i*4 +: 4])) - int'($signed(b[i*4 +: 4]));
      s[i] = (d > 7) || (d < -8);
    end
    return s;
  endfunction

  function automatic logic [15:0] lane_mask(input int nlanes);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < nlanes; i++) m[i*4 +: 4] = 4'hF;
    return m;
  endfunction

  // Timeline model: phase 0 = no operation, 1..4 = running with phase-1 lanes done, 5 = done cycle.
  int          m_phase = 0;
  logic [15:0] m_res   = '0;
  logic [3:0]  m_sat   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_res   <= '0;
      m_sat   <= '0;
    end else if ((m_phase == 0 || m_phase == 5) && start) begin
      m_phase <= 1;
      m_res   <= ref_diff(A, B);
      m_sat   <= ref_sat(A, B);
    end else if (m_phase >= 1 && m_phase <= 4) begin
      m_phase <= m_phase + 1;
    end else begin
      m_phase <= 0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] e_diff;
      logic [3:0]  e_sat;
      if (m_phase >= 1 && m_phase <= 4) begin
        e_diff = m_res & lane_mask(m_phase - 1);
        e_sat  = m_sat & 4'((1 << (m_phase - 1)) - 1);
      end else begin
        e_diff = m_res;
        e_sat  = m_sat;
      end
      chk("model_busy", 16'(busy), 16'(m_phase >= 1 && m_phase <= 4));
      chk("model_done", 16'(done), 16'(m_phase == 5));
      chk("model_diff", Diff, e_diff);
`ifdef PSUBSB_FLAGS_EN
      chk("model_sat", 16'(sat), 16'(e_sat));
`else
      if (e_sat == 4'hF && e_diff == 16'hFFFF) checks += 0;
`endif
    end
  end

  // Issue one operation from a negedge and return at the negedge of its done cycle.
  task automatic op(input string name, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] exp_d, input logic [3:0] exp_s);
    int cyc;
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, 16'(cyc), 16'd4);
    chk({name, "_diff"}, Diff, exp_d);
`ifdef PSUBSB_FLAGS_EN
    chk({name, "_sat"}, 16'(sat), 16'(exp_s));
`else
    if (exp_s == 4'hF && exp_d == 16'hFFFF) checks += 0;
`endif
  endtask

  initial begin
    int ndone;
    repeat (2) @(negedge clk);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_diff", Diff, 16'h0000);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Literal expectations that pin the model as well as the DUT.
    chk("pin_model_plain", ref_diff(16'h1234, 16'h1111), 16'h0123);
    chk("pin_model_possat", ref_diff(16'h7070, 16'h8080), 16'h7070);
    chk("pin_model_satflags", 16'(ref_sat(16'h7070, 16'h8080)), 16'h000A);

    op("plain",   16'h1234, 16'h1111, 16'h0123, 4'b0000);
    @(negedge clk);
    op("possat",  16'h7070, 16'h8080, 16'h7070, 4'b1010);
    @(negedge clk);
    op("negsat",  16'h8888, 16'h1111, 16'h8888, 4'b1111);
    @(negedge clk);
    op("borrow",  16'h0000, 16'h0001, 16'h000F, 4'b0000);
    repeat (2) @(negedge clk);

    // Reset on the second busy cycle discards the partial result.
    A = 16'h7777; B = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 16'(busy), 16'd0);
    chk("rst_mid_done", 16'(done), 16'd0);
    chk("rst_mid_diff", Diff, 16'h0000);
    rst = 1'b0;
    op("after_rst", 16'h1234, 16'h1111, 16'h0123, 4'b0000);
    @(negedge clk);

    // A start pulse during RUN must not queue a second operation.
    A = 16'h1234; B = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'hFFFF; B = 16'h8888; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        ndone++;
        chk("run_start_diff", Diff, 16'h0123);
      end
      @(negedge clk);
    end
    chk("run_start_ndone", 16'(ndone), 16'd1);

    // Back-to-back: second op launched in the done cycle of the first.
    op("b2b_first",  16'h1234, 16'h1111, 16'h0123, 4'b0000);
    op("b2b_second", 16'h5555, 16'h2222, 16'h3333, 4'b0000);
    @(negedge clk);

    // Randomized traffic, including start/rst collisions, against the model.
    for (int i = 0; i < 600; i++) begin
      A     = 16'($urandom);
      B     = 16'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
